// File: rtl/gpio_expander_core_pkg.sv
// Shared definitions for the GPIO expander core: register map, channel modes, FSM states.
// Address constants are 7-bit because the command byte's MSB selects write vs read.
// Channel-indexed registers live at a base address plus channel number (0..15).
package gpio_expander_core_pkg;

  localparam logic [6:0] ADDR_ID        = 7'h00;
  localparam logic [6:0] ADDR_CTRL      = 7'h01;
  localparam logic [6:0] ADDR_OUT0      = 7'h10;
  localparam logic [6:0] ADDR_OUT1      = 7'h11;
  localparam logic [6:0] ADDR_MODE_BASE = 7'h20;
  localparam logic [6:0] ADDR_DUTY_BASE = 7'h40;

  typedef enum logic [1:0] {
    MODE_STATIC     = 2'd0,
    MODE_PWM        = 2'd1,
    MODE_BLINK      = 2'd2,
    MODE_STATIC_ALT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

endpackage

// File: rtl/gpio_expander_core_pwm_channel.sv
// Per-channel mode selection: static bit, PWM compare against shared counter, or gated blink.
// Purely combinational; the core registers the result together with enable/invert.
// All channels share cnt and blink, so PWM edges are phase-aligned across channels.
module gpio_expander_core_pwm_channel
  import gpio_expander_core_pkg::*;
(
  input  logic [7:0] cnt,
  input  logic       blink,
  input  logic [1:0] mode,
  input  logic [7:0] duty,
  input  logic       out_bit,
  output logic       mode_out
);

  // Select the channel waveform; codes 0 and 3 both mean static
  always_comb begin
    mode_out = out_bit;
    case (mode_e'(mode))
      MODE_PWM:   mode_out = (cnt < duty);
      MODE_BLINK: mode_out = out_bit & blink;
      default:    mode_out = out_bit;
    endcase
  end

endmodule

// File: rtl/gpio_expander_core.sv
// Register-mapped output expander: decodes SPI command/burst bytes into a per-channel register file.
// Register write lands on the data_rdy edge; chip_out follows one edge later; data_latch 1 cycle after data_rdy.
// No backpressure: every data_rdy inside an active frame is consumed; bytes outside a frame are dropped.
module gpio_expander_core
  import gpio_expander_core_pkg::*;
#(
  parameter int         N_OUT        = 7,
  parameter int         PWM_PRESCALE = 4,
  parameter int         BLINK_BITS   = 7,
  parameter logic [7:0] DEVICE_ID    = 8'hA5
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             frame_active,
  input  logic [7:0]       data_in,
  input  logic             data_rdy,
  output logic [7:0]       data_out,
  output logic             data_latch,
  output logic [N_OUT-1:0] chip_out
);

  localparam int              PS_W    = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PWM_PRESCALE - 1);

  logic [1:0]            rst_q;
  logic                  rst_int;
  state_e                state, state_nxt;
  logic [6:0]            addr, addr_nxt, rd_addr;
  logic                  wr_en, ld_en;
  logic [7:0]            rd_data;
  logic [15:0]           out16;
  logic [1:0]            ctrl;
  logic [N_OUT-1:0]      out_bits;
  logic [1:0]            mode_r [N_OUT];
  logic [7:0]            duty_r [N_OUT];
  logic [PS_W-1:0]       presc;
  logic                  tick;
  logic [7:0]            cnt;
  logic [BLINK_BITS-1:0] bper;
  logic                  blink;
  logic [N_OUT-1:0]      mode_out;

  // Reset asserts immediately but releases only after two clean clock edges
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) rst_q <= 2'b11;
    else     rst_q <= {rst_q[0], 1'b0};
  end
  assign rst_int = rst_q[1];

  // FSM state register
  always_ff @(posedge sys_clk or posedge rst_int) begin
    if (rst_int) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state, address advance, write strobe and read-load strobe
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    wr_en     = 1'b0;
    ld_en     = 1'b0;
    rd_addr   = addr + 7'd1;
    if (!frame_active) begin
      state_nxt = ST_IDLE;
    end else if (data_rdy) begin
      case (state)
        ST_IDLE: begin
          addr_nxt = data_in[6:0];
          if (data_in[7]) begin
            state_nxt = ST_WRITE;
          end else begin
            state_nxt = ST_READ;
            ld_en     = 1'b1;
            rd_addr   = data_in[6:0];
          end
        end
        ST_WRITE: begin
          wr_en    = 1'b1;
          addr_nxt = addr + 7'd1;
        end
        ST_READ: begin
          ld_en    = 1'b1;
          addr_nxt = addr + 7'd1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign out16 = 16'(out_bits);

  // Read mux; unmapped addresses and channels beyond N_OUT read as zero
  always_comb begin
    rd_data = 8'h00;
    if (rd_addr == ADDR_ID)        rd_data = DEVICE_ID;
    else if (rd_addr == ADDR_CTRL) rd_data = {6'b0, ctrl};
    else if (rd_addr == ADDR_OUT0) rd_data = out16[7:0];
    else if (rd_addr == ADDR_OUT1) rd_data = out16[15:8];
    else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (rd_addr == ADDR_MODE_BASE + 7'(k)) rd_data = {6'b0, mode_r[k]};
        if (rd_addr == ADDR_DUTY_BASE + 7'(k)) rd_data = duty_r[k];
      end
    end
  end

  // Address pointer and SPI return byte; data_latch is a single-cycle load strobe
  always_ff @(posedge sys_clk or posedge rst_int) begin
    if (rst_int) begin
      addr       <= 7'h00;
      data_out   <= 8'h00;
      data_latch <= 1'b0;
    end else begin
      addr       <= addr_nxt;
      data_latch <= ld_en;
      if (ld_en) data_out <= rd_data;
    end
  end

  // Register file writes; the ID and unmapped locations silently absorb data
  always_ff @(posedge sys_clk or posedge rst_int) begin
    if (rst_int) begin
      ctrl     <= 2'b00;
      out_bits <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        mode_r[k] <= 2'b00;
        duty_r[k] <= 8'h00;
      end
    end else if (wr_en) begin
      if (addr == ADDR_CTRL) ctrl <= data_in[1:0];
      for (int k = 0; k < N_OUT; k++) begin
        if (k < 8 && addr == ADDR_OUT0)         out_bits[k] <= data_in[k % 8];
        if (k >= 8 && addr == ADDR_OUT1)        out_bits[k] <= data_in[k % 8];
        if (addr == ADDR_MODE_BASE + 7'(k))     mode_r[k]   <= data_in[1:0];
        if (addr == ADDR_DUTY_BASE + 7'(k))     duty_r[k]   <= data_in;
      end
    end
  end

  assign tick = (presc == PS_LAST);

  // Free-running prescaler, PWM tick counter and blink toggle, independent of SPI traffic
  always_ff @(posedge sys_clk or posedge rst_int) begin
    if (rst_int) begin
      presc <= '0;
      cnt   <= 8'h00;
      bper  <= '0;
      blink <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        cnt <= cnt + 8'd1;
        if (cnt == 8'hFF) begin
          bper <= bper + 1'b1;
          if (&bper) blink <= ~blink;
        end
      end
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_chan
    gpio_expander_core_pwm_channel u_chan (
      .cnt      (cnt),
      .blink    (blink),
      .mode     (mode_r[g]),
      .duty     (duty_r[g]),
      .out_bit  (out_bits[g]),
      .mode_out (mode_out[g])
    );
  end

  // Registered outputs with global enable and polarity invert
  always_ff @(posedge sys_clk or posedge rst_int) begin
    if (rst_int) chip_out <= '0;
    else         chip_out <= ctrl[0] ? (mode_out ^ {N_OUT{ctrl[1]}}) : '0;
  end

endmodule

// File: tb/tb_gpio_expander_core.sv
// Directed bench for gpio_expander_core: reset, static/burst writes, PWM/blink duty, read-back, wrap.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected values are hand-computed constants for N_OUT=7, PWM_PRESCALE=4, BLINK_BITS=1.
module tb_gpio_expander_core;

  localparam int N_OUT = 7;

  logic             sys_clk = 1'b0;
  logic             rst = 1'b1;
  logic             frame_active = 1'b0;
  logic [7:0]       data_in = 8'h00;
  logic             data_rdy = 1'b0;
  logic [7:0]       data_out;
  logic             data_latch;
  logic [N_OUT-1:0] chip_out;

  int checks = 0;
  int failures = 0;
  int hi;

  always #5 sys_clk = ~sys_clk;

  gpio_expander_core #(
    .N_OUT        (N_OUT),
    .PWM_PRESCALE (4),
    .BLINK_BITS   (1),
    .DEVICE_ID    (8'hA5)
  ) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .frame_active (frame_active),
    .data_in      (data_in),
    .data_rdy     (data_rdy),
    .data_out     (data_out),
    .data_latch   (data_latch),
    .chip_out     (chip_out)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Returns on the falling edge right after the byte was sampled
  task automatic send(input logic [7:0] b);
    data_in  = b;
    data_rdy = 1'b1;
    @(negedge sys_clk);
    data_rdy = 1'b0;
  endtask

  task automatic frame_begin();
    frame_active = 1'b1;
    cyc(1);
  endtask

  task automatic frame_end();
    frame_active = 1'b0;
    cyc(2);
  endtask

  task automatic write2(input logic [7:0] cmd, input logic [7:0] d);
    frame_begin();
    send(cmd);
    send(d);
    frame_end();
  endtask

  // Send one byte of a read frame and check the returned byte and latch pulse
  task automatic read_byte(input string tag, input logic [7:0] b, input int exp);
    send(b);
    chk({tag, "_latch"}, int'(data_latch), 1);
    chk(tag, int'(data_out), exp);
    cyc(1);
    chk({tag, "_latch_low"}, int'(data_latch), 0);
  endtask

  task automatic count_high(input int ch, input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge sys_clk);
      if (chip_out[ch]) cnt++;
    end
  endtask

  initial begin
    // Reset state
    cyc(3);
    chk("rst_chip_out", int'(chip_out), 0);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_latch", int'(data_latch), 0);
    rst = 1'b0;
    cyc(4);

    // Reset in the middle of a write burst
    frame_begin();
    send(8'h90);
    send(8'h7F);
    rst = 1'b1;
    cyc(2);
    chk("midburst_rst_out", int'(chip_out), 0);
    rst = 1'b0;
    cyc(4);
    send(8'h81);
    send(8'h03);
    cyc(1);
    chk("post_rst_cmd_invert", int'(chip_out), 'h7F);
    frame_end();
    write2(8'h81, 8'h01);
    chk("ctrl_enable_only", int'(chip_out), 0);

    // Static write with one-edge output latency
    frame_begin();
    send(8'h90);
    send(8'h55);
    chk("static_pre", int'(chip_out), 0);
    cyc(1);
    chk("static_post", int'(chip_out), 'h55);
    frame_end();

    // Frame drop coincident with data_rdy discards the byte
    frame_begin();
    frame_active = 1'b0;
    data_in      = 8'h81;
    data_rdy     = 1'b1;
    cyc(1);
    data_rdy     = 1'b0;
    chk("drop_latch", int'(data_latch), 0);
    frame_active = 1'b1;
    cyc(1);
    read_byte("drop_then_cmd", 8'h03, 0);
    cyc(1);
    chk("drop_ctrl_kept", int'(chip_out), 'h55);
    frame_end();

    // data_rdy with no frame is ignored
    send(8'h00);
    chk("noframe_latch", int'(data_latch), 0);
    cyc(1);

    // Burst writes: MODE ch0..2 = PWM, DUTY ch0..2 = 64, 0, 255
    frame_begin();
    send(8'hA0); send(8'h01); send(8'h01); send(8'h01);
    frame_end();
    frame_begin();
    send(8'hC0); send(8'd64); send(8'd0); send(8'd255);
    frame_end();
    cyc(4);
    count_high(0, 1024, hi);
    chk("pwm_duty64", hi, 256);
    count_high(1, 1024, hi);
    chk("pwm_duty0", hi, 0);
    count_high(2, 1024, hi);
    chk("pwm_duty255", hi, 1020);
    chk("static_upper", int'(chip_out[6:3]), 'hA);

    // Read-back burst
    frame_begin();
    read_byte("rd_id", 8'h00, 'hA5);
    read_byte("rd_ctrl", 8'hFF, 'h01);
    read_byte("rd_addr2", 8'hFF, 'h00);
    frame_end();
    frame_begin(); read_byte("rd_out0", 8'h10, 'h55); frame_end();
    frame_begin(); read_byte("rd_mode1", 8'h21, 'h01); frame_end();
    frame_begin(); read_byte("rd_duty2", 8'h42, 'hFF); frame_end();

    // Read address wrap 0x7F -> 0x00
    frame_begin();
    read_byte("rd_7f", 8'h7F, 'h00);
    read_byte("rd_wrap_id", 8'h00, 'hA5);
    frame_end();

    // Write to a channel beyond N_OUT is ignored
    write2(8'hA7, 8'h02);
    frame_begin(); read_byte("rd_mode_oob", 8'h27, 'h00); frame_end();

    // Write address wrap: 0x7F, 0x00 (both ignored), then CTRL
    frame_begin();
    send(8'hFF); send(8'h00); send(8'h00); send(8'h03);
    frame_end();
    frame_begin(); read_byte("rd_ctrl_wrap", 8'h01, 'h03); frame_end();
    chk("invert_upper", int'(chip_out[6:3]), 'h5);
    write2(8'h81, 8'h02);
    chk("disabled_out", int'(chip_out), 0);

    // Blink on ch3: toggle every 2 PWM periods (2048 cycles)
    write2(8'h81, 8'h01);
    write2(8'hA3, 8'h02);
    write2(8'h90, 8'h08);
    cyc(2);
    chk("blink_ch4_static", int'(chip_out[4]), 0);
    count_high(3, 8192, hi);
    chk("blink_ch3_high", hi, 4096);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
